uart_tx_mux: RTL and testbench

Parametrised UART transmit scheduler. It takes N_CH channel words, frames each one as a header byte plus payload bytes, and streams the frames into the UART TX FIFO. Channels are served in round-robin order and writes are throttled by the FIFO full flag. The block sits between the game-state producers (mouse/player data) and the UART TX FIFO, and generalises the two-channel single-byte UART feeder.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_mux_if.sv | 26 ++
 rtl/uart_rr_ptr.sv | 70 +++++++
 rtl/uart_tx_mux.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_mux.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and header formatting for the UART TX scheduler.
// Pure definitions; no latency. No flow control of its own.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_HDR,
        ST_PAY,
        ST_GAP
    } uart_mux_state_t;

    localparam logic [3:0] UART_HDR_SYNC = 4'hA;

    // Sync nibble in the high half lets a receiver realign after a torn frame.
    function automatic logic [7:0] mk_hdr(input logic [3:0] ch);
        return {UART_HDR_SYNC, ch};
    endfunction

endpackage

// File: rtl/uart_tx_mux_if.sv
// Channel-word inputs and FIFO write port of the UART TX scheduler.
// Wires only; no latency. Backpressure is carried on tx_full.
interface uart_tx_mux_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 16
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                   en;
    logic [N_CH*DATA_W-1:0] data_in;
    logic                   tx_full;
    logic                   wr_uart;
    logic [7:0]             w_data;
    logic                   busy;
    logic [CH_W-1:0]        ch_idx;

    modport master (
        input  en, data_in, tx_full,
        output wr_uart, w_data, busy, ch_idx
    );

    modport slave (
        output en, data_in, tx_full,
        input  wr_uart, w_data, busy, ch_idx
    );
endinterface

// File: rtl/uart_rr_ptr.sv
// Round-robin channel pointer; with UART_TX_MUX_CHANGE_ONLY_EN also the unchanged-word skip test.
// Pointer moves on the edge after advance; skip is combinational from the current pointer.
// No backpressure; the caller decides when to advance.
module uart_rr_ptr #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 16,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
`ifdef UART_TX_MUX_CHANGE_ONLY_EN
    input  logic [DATA_W-1:0] cur_word,
    input  logic              commit,
    input  logic [DATA_W-1:0] commit_word,
    output logic              skip,
`endif
    output logic [PTR_W-1:0]  ptr
);

    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (ptr_q == PTR_W'(N_CH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

`ifdef UART_TX_MUX_CHANGE_ONLY_EN
    logic [DATA_W-1:0] last_sent_q [N_CH];
    logic [DATA_W-1:0] last_sent_d [N_CH];
    logic [N_CH-1:0]   valid_q, valid_d;

    // Commit happens while ptr still names the channel whose frame is finishing.
    always_comb begin
        last_sent_d = last_sent_q;
        valid_d     = valid_q;
        if (commit) begin
            last_sent_d[ptr_q] = commit_word;
            valid_d[ptr_q]     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                last_sent_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            last_sent_q <= last_sent_d;
            valid_q     <= valid_d;
        end
    end

    assign skip = valid_q[ptr_q] && (cur_word == last_sent_q[ptr_q]);
`endif

endmodule

// File: rtl/uart_tx_mux.sv
// Round-robin framer: header {0xA,ch} plus MSB-first payload bytes into a UART TX FIFO (option UART_TX_MUX_CHANGE_ONLY_EN).
// First header write 3 cycles after en rises; one idle cycle follows every write.
// tx_full holds the frame in HDR/PAY without dropping or repeating bytes.
module uart_tx_mux
    import uart_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 16
) (
    input logic           clk,
    input logic           rst_n,
    uart_tx_mux_if.master bus
);

    localparam int B     = DATA_W / 8;
    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BC_W  = (B > 1) ? $clog2(B) : 1;

    uart_mux_state_t   state_q, state_d;
    logic [DATA_W-1:0] frame_q, frame_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [PTR_W-1:0]  ch_idx_q, ch_idx_d;
    logic              wr_uart_q, wr_uart_d;
    logic [7:0]        w_data_q, w_data_d;
    logic              busy_q, busy_d;
    logic              gap_hdr_q, gap_hdr_d;

    logic [PTR_W-1:0]  ptr;
    logic              advance;
    logic [DATA_W-1:0] sel_word;
    logic [7:0]        pay_byte;
    logic              last_byte;

`ifdef UART_TX_MUX_CHANGE_ONLY_EN
    logic skip;
    logic commit;
`endif

    assign sel_word  = bus.data_in[ptr*DATA_W +: DATA_W];
    assign last_byte = (byte_cnt_q == BC_W'(B - 1));

    // byte_cnt 0 addresses the most significant byte of the snapshot.
    always_comb begin
        pay_byte = 8'h00;
        for (int b = 0; b < B; b++) begin
            if (byte_cnt_q == BC_W'(B - 1 - b)) begin
                pay_byte = frame_q[b*8 +: 8];
            end
        end
    end

    uart_rr_ptr #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_rr_ptr (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance     (advance),
`ifdef UART_TX_MUX_CHANGE_ONLY_EN
        .cur_word    (sel_word),
        .commit      (commit),
        .commit_word (frame_q),
        .skip        (skip),
`endif
        .ptr         (ptr)
    );

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        byte_cnt_d = byte_cnt_q;
        ch_idx_d   = ch_idx_q;
        w_data_d   = w_data_q;
        gap_hdr_d  = gap_hdr_q;
        wr_uart_d  = 1'b0;
        advance    = 1'b0;
`ifdef UART_TX_MUX_CHANGE_ONLY_EN
        commit     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.en) begin
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
`ifdef UART_TX_MUX_CHANGE_ONLY_EN
                if (skip) begin
                    advance = 1'b1;
                    state_d = bus.en ? ST_SELECT : ST_IDLE;
                end else
`endif
                begin
                    frame_d  = sel_word;
                    ch_idx_d = ptr;
                    state_d  = ST_HDR;
                end
            end
            ST_HDR: begin
                if (!bus.tx_full) begin
                    wr_uart_d = 1'b1;
                    w_data_d  = mk_hdr(4'(ch_idx_q));
                    gap_hdr_d = 1'b1;
                    state_d   = ST_GAP;
                end
            end
            ST_PAY: begin
                if (!bus.tx_full) begin
                    wr_uart_d = 1'b1;
                    w_data_d  = pay_byte;
                    gap_hdr_d = 1'b0;
                    state_d   = ST_GAP;
`ifdef UART_TX_MUX_CHANGE_ONLY_EN
                    commit    = last_byte;
`endif
                end
            end
            ST_GAP: begin
                // The idle cycle lets tx_full catch up with the write just made.
                if (gap_hdr_q) begin
                    state_d = ST_PAY;
                end else if (!last_byte) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    state_d    = ST_PAY;
                end else begin
                    advance    = 1'b1;
                    byte_cnt_d = '0;
                    state_d    = bus.en ? ST_SELECT : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            frame_q    <= '0;
            byte_cnt_q <= '0;
            ch_idx_q   <= '0;
            wr_uart_q  <= 1'b0;
            w_data_q   <= 8'h00;
            busy_q     <= 1'b0;
            gap_hdr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            byte_cnt_q <= byte_cnt_d;
            ch_idx_q   <= ch_idx_d;
            wr_uart_q  <= wr_uart_d;
            w_data_q   <= w_data_d;
            busy_q     <= busy_d;
            gap_hdr_q  <= gap_hdr_d;
        end
    end

    assign bus.wr_uart = wr_uart_q;
    assign bus.w_data  = w_data_q;
    assign bus.busy    = busy_q;
    assign bus.ch_idx  = ch_idx_q;

endmodule

// File: tb/tb_uart_tx_mux.sv
// Directed bench for uart_tx_mux: cycle table for the first frames, then hand-written corner sequences.
module tb_uart_tx_mux;

    localparam int N_CH   = 4;
    localparam int DATA_W = 16;

    logic clk;
    logic rst_n;

    uart_tx_mux_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

    uart_tx_mux #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic       en;
        logic       tx_full;
        logic       exp_wr;
        logic [7:0] exp_data;
        logic       exp_busy;
        logic [1:0] exp_ch;
    } vec_t;

    vec_t vecs[18];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    logic mon_on;
    logic [7:0] wq[$];
    int wcyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_on && bus.wr_uart === 1'b1) begin
            wq.push_back(bus.w_data);
            wcyc.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic [15:0] w);
        bus.data_in[ch*DATA_W +: DATA_W] = w;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.en      = 1'b0;
        bus.tx_full = 1'b0;
        mon_on      = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wq.delete();
        wcyc.delete();
    endtask

    task automatic collect(input int nwr, input int budget);
        int n;
        n = 0;
        while (wq.size() < nwr && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("collect_timeout", 32'(wq.size() >= nwr), 32'd1);
    endtask

    task automatic wait_byte(input logic [7:0] b, input int budget);
        int n;
        n = 0;
        while (!(bus.wr_uart === 1'b1 && bus.w_data == b) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("wait_byte", 32'(bus.w_data), 32'(b));
    endtask

    initial begin
        logic [7:0] exp_q[$];

        //             en   tf   wr   data   busy ch
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'hA0, 1'b1, 2'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 8'h12, 1'b1, 2'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'h34, 1'b1, 2'd0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 2'd1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h56, 1'b1, 2'd1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd1};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 8'h78, 1'b1, 2'd1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd1};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd1};

        bus.data_in = '0;
        rst_n       = 1'b0;
        bus.en      = 1'b0;
        bus.tx_full = 1'b0;
        mon_on      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr",     32'(bus.wr_uart), 32'd0);
        chk("rst_w_data", 32'(bus.w_data),  32'd0);
        chk("rst_busy",   32'(bus.busy),    32'd0);
        chk("rst_ch_idx", 32'(bus.ch_idx),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: ch0 frame, ch1 frame with a header stall and en dropped mid-frame.
        set_ch(0, 16'h1234);
        set_ch(1, 16'h5678);
        for (int i = 0; i < 18; i++) begin
            bus.en      = vecs[i].en;
            bus.tx_full = vecs[i].tx_full;
            @(negedge clk);
            chk($sformatf("vec%0d_wr", i),   32'(bus.wr_uart), 32'(vecs[i].exp_wr));
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy),    32'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_ch", i),   32'(bus.ch_idx),  32'(vecs[i].exp_ch));
            if (vecs[i].exp_wr) begin
                chk($sformatf("vec%0d_data", i), 32'(bus.w_data), 32'(vecs[i].exp_data));
            end
        end

`ifndef UART_TX_MUX_CHANGE_ONLY_EN
        // Full round with write spacing: 2 inside a frame, 3 across a frame boundary.
        do_reset();
        for (int c = 0; c < N_CH; c++) set_ch(c, 16'h0101 * 16'(c + 1));
        exp_q.delete();
        for (int c = 0; c < N_CH; c++) begin
            exp_q.push_back(8'hA0 | 8'(c));
            exp_q.push_back(8'(c + 1));
            exp_q.push_back(8'(c + 1));
        end
        exp_q.push_back(8'hA0);
        mon_on = 1'b1;
        bus.en = 1'b1;
        collect(13, 200);
        for (int k = 0; k < 13 && k < wq.size(); k++) begin
            chk($sformatf("round_byte%0d", k), 32'(wq[k]), 32'(exp_q[k]));
            if (k > 0) begin
                chk($sformatf("round_gap%0d", k), 32'(wcyc[k] - wcyc[k-1]),
                    (k % 3 == 0) ? 32'd3 : 32'd2);
            end
        end

        // Snapshot: ch0 changes after its header is written.
        do_reset();
        for (int c = 0; c < N_CH; c++) set_ch(c, 16'h0101 * 16'(c + 1));
        set_ch(0, 16'h1234);
        mon_on = 1'b1;
        bus.en = 1'b1;
        collect(1, 20);
        set_ch(0, 16'hBEEF);
        collect(15, 200);
        if (wq.size() >= 15) begin
            chk("snap_pay0",  32'(wq[1]),  32'h12);
            chk("snap_pay1",  32'(wq[2]),  32'h34);
            chk("snap_hdr",   32'(wq[12]), 32'hA0);
            chk("snap_next0", 32'(wq[13]), 32'hBE);
            chk("snap_next1", 32'(wq[14]), 32'hEF);
        end

        // tx_full held for 10 cycles right after the header.
        do_reset();
        set_ch(0, 16'h1234);
        set_ch(1, 16'h5678);
        mon_on = 1'b1;
        bus.en = 1'b1;
        @(negedge clk);
        #1;
        wait_byte(8'hA0, 20);
        bus.tx_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("stall_nowr%0d", i), 32'(bus.wr_uart), 32'd0);
        end
        bus.tx_full = 1'b0;
        @(negedge clk);
        #1;
        chk("stall_release_wr",   32'(bus.wr_uart), 32'd1);
        chk("stall_release_data", 32'(bus.w_data),  32'h12);
        collect(4, 30);
        chk("stall_count_early", 32'(wq.size()), 32'd4);
        if (wq.size() >= 4) begin
            chk("stall_seq0", 32'(wq[0]), 32'hA0);
            chk("stall_seq1", 32'(wq[1]), 32'h12);
            chk("stall_seq2", 32'(wq[2]), 32'h34);
            chk("stall_seq3", 32'(wq[3]), 32'hA1);
        end

        // Asynchronous reset mid-frame on ch1, then restart from ch0.
        do_reset();
        set_ch(0, 16'h1234);
        set_ch(1, 16'h5678);
        bus.en = 1'b1;
        @(negedge clk);
        #1;
        wait_byte(8'hA1, 40);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_wr",     32'(bus.wr_uart), 32'd0);
        chk("arst_w_data", 32'(bus.w_data),  32'd0);
        chk("arst_busy",   32'(bus.busy),    32'd0);
        chk("arst_ch_idx", 32'(bus.ch_idx),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wq.delete();
        wcyc.delete();
        mon_on = 1'b1;
        collect(1, 20);
        if (wq.size() >= 1) chk("arst_restart_hdr", 32'(wq[0]), 32'hA0);
`else
        // Change-only: one full round, then silence; a single changed channel sends one frame.
        do_reset();
        for (int c = 0; c < N_CH; c++) set_ch(c, 16'h0101 * 16'(c + 1));
        mon_on = 1'b1;
        bus.en = 1'b1;
        collect(12, 200);
        repeat (60) @(negedge clk);
        #1;
        chk("co_round_count", 32'(wq.size()), 32'd12);
        if (wq.size() >= 12) chk("co_last_hdr", 32'(wq[9]), 32'hA3);
        wq.delete();
        wcyc.delete();
        set_ch(2, 16'hC0DE);
        repeat (60) @(negedge clk);
        #1;
        chk("co_change_count", 32'(wq.size()), 32'd3);
        if (wq.size() >= 3) begin
            chk("co_hdr",  32'(wq[0]), 32'hA2);
            chk("co_pay0", 32'(wq[1]), 32'hC0);
            chk("co_pay1", 32'(wq[2]), 32'hDE);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
